ioctl_xfer_master: RTL



---
 rtl/ioctl_xfer_master.sv | 241 ++++++++++++++++++++++++
 1 files changed

// File: rtl/ioctl_xfer_master.sv
// rtl/ioctl_xfer_master.sv - HPS ioctl byte-transfer initiator (download/upload)
// Optional IOCTL_XFER_CSUM_EN adds csum, the mod-256 sum of transferred bytes.
module ioctl_xfer_master #(
    parameter int LEN_WIDTH  = 16,
    parameter int WR_GAP     = 3,
    parameter int RD_LATENCY = 3
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 start,
    input  logic                 dir,
    input  logic [7:0]           index,
    input  logic [LEN_WIDTH-1:0] length,
    output logic                 busy,
    output logic                 done,
    input  logic [7:0]           src_data,
    input  logic                 src_valid,
    output logic                 src_ready,
    output logic [7:0]           snk_data,
    output logic                 snk_valid,
    input  logic                 snk_ready,
    output logic                 ioctl_download,
    output logic                 ioctl_upload,
    output logic                 ioctl_wr,
    output logic [24:0]          ioctl_addr,
    output logic [7:0]           ioctl_dout,
    input  logic [7:0]           ioctl_din,
`ifdef IOCTL_XFER_CSUM_EN
    output logic [7:0]           csum,
`endif
    output logic [7:0]           ioctl_index
);

    localparam logic [3:0] S_IDLE    = 4'd0;
    localparam logic [3:0] S_SETUP   = 4'd1;
    localparam logic [3:0] S_DL_SRC  = 4'd2;
    localparam logic [3:0] S_DL_WR   = 4'd3;
    localparam logic [3:0] S_DL_GAP  = 4'd4;
    localparam logic [3:0] S_UL_ADDR = 4'd5;
    localparam logic [3:0] S_UL_WAIT = 4'd6;
    localparam logic [3:0] S_UL_PUSH = 4'd7;
    localparam logic [3:0] S_FINISH  = 4'd8;
    localparam logic [3:0] S_DONE    = 4'd9;

    localparam int CNT_MAX = (WR_GAP > RD_LATENCY) ? WR_GAP : RD_LATENCY;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    logic [3:0]           state_q, state_d;
    logic                 busy_q, busy_d, done_q, done_d, dir_q, dir_d;
    logic [7:0]           index_q, index_d, ioctl_index_q, ioctl_index_d;
    logic [LEN_WIDTH-1:0] len_q, len_d, addr_q, addr_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 src_ready_q, src_ready_d, wr_q, wr_d;
    logic [7:0]           dout_q, dout_d, snk_data_q, snk_data_d;
    logic                 snk_valid_q, snk_valid_d, dl_q, dl_d, ul_q, ul_d;
    logic                 gap_exit;
`ifdef IOCTL_XFER_CSUM_EN
    logic [7:0]           csum_q, csum_d;
`endif

    always_comb begin
        state_d       = state_q;
        busy_d        = busy_q;
        done_d        = 1'b0;
        dir_d         = dir_q;
        index_d       = index_q;
        ioctl_index_d = ioctl_index_q;
        len_d         = len_q;
        addr_d        = addr_q;
        cnt_d         = cnt_q;
        src_ready_d   = 1'b0;
        wr_d          = 1'b0;
        dout_d        = dout_q;
        snk_data_d    = snk_data_q;
        snk_valid_d   = snk_valid_q;
        dl_d          = dl_q;
        ul_d          = ul_q;
        gap_exit      = 1'b0;
`ifdef IOCTL_XFER_CSUM_EN
        csum_d        = csum_q;
`endif
        case (state_q)
            S_IDLE: if (start) begin
                busy_d  = 1'b1;
                dir_d   = dir;
                index_d = index;
                len_d   = length;
                state_d = S_SETUP;
`ifdef IOCTL_XFER_CSUM_EN
                csum_d  = 8'd0;
`endif
            end
            S_SETUP: begin
                ioctl_index_d = index_q;
                addr_d        = '0;
                dl_d          = ~dir_q;
                ul_d          = dir_q;
                if (len_q == '0) begin
                    state_d = S_FINISH;
                end else if (dir_q) begin
                    state_d = S_UL_ADDR;
                end else begin
                    state_d     = S_DL_SRC;
                    src_ready_d = 1'b1;
                end
            end
            S_DL_SRC: begin
                if (src_valid && src_ready_q) begin
                    dout_d  = src_data;
                    wr_d    = 1'b1;
                    state_d = S_DL_WR;
                end else begin
                    src_ready_d = 1'b1;
                end
            end
            S_DL_WR: begin
`ifdef IOCTL_XFER_CSUM_EN
                csum_d = csum_q + dout_q;
`endif
                // DL_SRC counts as one of the idle cycles, so DL_GAP holds WR_GAP-1.
                if (WR_GAP <= 1) begin
                    gap_exit = 1'b1;
                end else begin
                    cnt_d   = CNT_W'(WR_GAP - 2);
                    state_d = S_DL_GAP;
                end
            end
            S_DL_GAP: begin
                if (cnt_q == '0) gap_exit = 1'b1;
                else             cnt_d = cnt_q - CNT_W'(1);
            end
            S_UL_ADDR: begin
                cnt_d   = CNT_W'(RD_LATENCY - 1);
                state_d = S_UL_WAIT;
            end
            S_UL_WAIT: begin
                if (cnt_q == '0) begin
                    snk_data_d  = ioctl_din;
                    snk_valid_d = 1'b1;
                    state_d     = S_UL_PUSH;
`ifdef IOCTL_XFER_CSUM_EN
                    csum_d      = csum_q + ioctl_din;
`endif
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_UL_PUSH: if (snk_ready) begin
                snk_valid_d = 1'b0;
                if (addr_q == len_q - LEN_WIDTH'(1)) begin
                    state_d = S_FINISH;
                end else begin
                    addr_d  = addr_q + LEN_WIDTH'(1);
                    state_d = S_UL_ADDR;
                end
            end
            S_FINISH: begin
                dl_d    = 1'b0;
                ul_d    = 1'b0;
                state_d = S_DONE;
            end
            S_DONE: begin
                done_d        = 1'b1;
                busy_d        = 1'b0;
                ioctl_index_d = 8'd0;
                state_d       = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        if (gap_exit) begin
            if (addr_q == len_q - LEN_WIDTH'(1)) begin
                state_d = S_FINISH;
            end else begin
                addr_d      = addr_q + LEN_WIDTH'(1);
                state_d     = S_DL_SRC;
                src_ready_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= S_IDLE;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            dir_q         <= 1'b0;
            index_q       <= 8'd0;
            ioctl_index_q <= 8'd0;
            len_q         <= '0;
            addr_q        <= '0;
            cnt_q         <= '0;
            src_ready_q   <= 1'b0;
            wr_q          <= 1'b0;
            dout_q        <= 8'd0;
            snk_data_q    <= 8'd0;
            snk_valid_q   <= 1'b0;
            dl_q          <= 1'b0;
            ul_q          <= 1'b0;
`ifdef IOCTL_XFER_CSUM_EN
            csum_q        <= 8'd0;
`endif
        end else begin
            state_q       <= state_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            dir_q         <= dir_d;
            index_q       <= index_d;
            ioctl_index_q <= ioctl_index_d;
            len_q         <= len_d;
            addr_q        <= addr_d;
            cnt_q         <= cnt_d;
            src_ready_q   <= src_ready_d;
            wr_q          <= wr_d;
            dout_q        <= dout_d;
            snk_data_q    <= snk_data_d;
            snk_valid_q   <= snk_valid_d;
            dl_q          <= dl_d;
            ul_q          <= ul_d;
`ifdef IOCTL_XFER_CSUM_EN
            csum_q        <= csum_d;
`endif
        end
    end

    assign busy           = busy_q;
    assign done           = done_q;
    assign src_ready      = src_ready_q;
    assign snk_data       = snk_data_q;
    assign snk_valid      = snk_valid_q;
    assign ioctl_download = dl_q;
    assign ioctl_upload   = ul_q;
    assign ioctl_wr       = wr_q;
    assign ioctl_addr     = 25'(addr_q);
    assign ioctl_dout     = dout_q;
    assign ioctl_index    = ioctl_index_q;
`ifdef IOCTL_XFER_CSUM_EN
    assign csum           = csum_q;
`endif

endmodule
